// File: rtl/writer_pkg.sv
// Shared stream-cipher transmit-side types and constants.
package writer_pkg;

   localparam int unsigned DATA_W = 8;

   // Pin-side 4-phase handshake states, visible to the interface FSM.
   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_ASSERT  = 2'd1,
      W_RELEASE = 2'd2
   } writer_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small circular byte FIFO; a push while full is accepted when a pop frees the slot.
module byte_fifo
   import writer_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    push,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    pop,
   output logic [DATA_W-1:0]       head_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rptr;
   logic [PW-1:0]     wptr;
   logic              do_push;
   logic              do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (!nrst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop)  rptr <= rptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care while the slot is not occupied.
   always_ff @(posedge clk) begin
      if (nrst && do_push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/writer.sv
// Transmit pin interface: buffers cipher byte pulses and drives a 4-phase req/ack handshake.
module writer
   import writer_pkg::*;
#(
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [DATA_W-1:0]       output_byte_in,
   input  logic                    output_byte_pulse,
   input  logic                    output_ack,
   output logic [DATA_W-1:0]       output_byte,
   output logic                    output_valid,
   output logic                    busy,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   writer_state_t           state;
   writer_state_t           state_next;
   logic [DATA_W-1:0]       byte_next;
   logic                    valid_next;
   logic                    pop;
   logic [DATA_W-1:0]       head_data;
   logic                    full;
   logic                    empty;
   logic [SYNC_STAGES-1:0]  ack_sync;
   logic                    ack_s;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (output_byte_pulse),
      .push_data (output_byte_in),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   assign ack_s = ack_sync[SYNC_STAGES-1];
   assign busy  = !empty || (state != W_IDLE);

   // Multi-flop synchronizer for the asynchronous ack pin.
   always_ff @(posedge clk) begin
      if (!nrst) ack_sync <= '0;
      else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], output_ack};
   end

   // Handshake state and registered pin outputs.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= W_IDLE;
         output_byte  <= '0;
         output_valid <= 1'b0;
      end else begin
         state        <= state_next;
         output_byte  <= byte_next;
         output_valid <= valid_next;
      end
   end

   // Next-state, pop strobe and next pin values.
   always_comb begin
      state_next = state;
      byte_next  = output_byte;
      pop        = 1'b0;
      case (state)
         W_IDLE: begin
            if (!empty && !ack_s) begin
               state_next = W_ASSERT;
               byte_next  = head_data;
            end
         end
         W_ASSERT: begin
            if (ack_s) begin
               state_next = W_RELEASE;
               pop        = 1'b1;
            end
         end
         W_RELEASE: begin
            if (!ack_s) state_next = W_IDLE;
         end
         default: state_next = W_IDLE;
      endcase
      valid_next = (state_next == W_ASSERT);
   end

   // Sticky flag for a byte arriving with no free slot.
   always_ff @(posedge clk) begin
      if (!nrst)                                   overflow <= 1'b0;
      else if (output_byte_pulse && full && !pop)  overflow <= 1'b1;
   end

endmodule

// File: tb/tb_writer.sv
// Self-checking bench for writer: scripted vector table, directed corner cases, random scoreboard.
module tb_writer;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned SYNC  = 2;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] din;
   logic       pulse;
   logic       ack;
   logic [7:0] output_byte;
   logic       output_valid;
   logic       busy;
   logic       overflow;
   logic [1:0] fifo_count;

   int total = 0;
   int bad   = 0;

   writer #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk               (clk),
      .nrst              (nrst),
      .output_byte_in    (din),
      .output_byte_pulse (pulse),
      .output_ack        (ack),
      .output_byte       (output_byte),
      .output_valid      (output_valid),
      .busy              (busy),
      .overflow          (overflow),
      .fifo_count        (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       p;
      logic [7:0] d;
      logic       a;
      logic       v;
      logic [7:0] b;
      int         c;
      logic       o;
      logic       bz;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t mk(logic p, logic [7:0] d, logic a,
                               logic v, logic [7:0] b, int c, logic o, logic bz);
      vec_t r;
      r.p = p; r.d = d; r.a = a; r.v = v; r.b = b; r.c = c; r.o = o; r.bz = bz;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for a request, check its byte, acknowledge it and check release latency.
   task automatic deliver(input logic [7:0] exp, input string nm);
      int n;
      n = 0;
      while (!output_valid && n < 20) begin tick(); n++; end
      chk({nm, "_req"}, int'(output_valid), 1);
      chk({nm, "_byte"}, int'(output_byte), int'(exp));
      ack = 1'b1;
      n = 0;
      do begin tick(); n++; end while (output_valid && n < 20);
      chk({nm, "_rel"}, n, SYNC + 1);
      ack = 1'b0;
      repeat (SYNC + 1) tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q [$];
      logic       movf;
      logic       ack_seen_fall;
      int         ack_wait;
      int         ack_edges;
      logic       pv;
      logic       fell;
      logic       rose;
      logic       acc;
      logic [7:0] held;

      nrst = 1'b0; din = '0; pulse = 1'b0; ack = 1'b0;
      repeat (2) tick();
      chk("rst_valid", int'(output_valid), 0);
      chk("rst_byte", int'(output_byte), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
      nrst = 1'b1;
      repeat (3) tick();

      // Single byte handshake followed by a stuck-high ack case.
      tbl[0]  = mk(1, 8'hA5, 0,  0, 8'h00, 1, 0, 1);
      tbl[1]  = mk(0, 8'h00, 0,  1, 8'hA5, 1, 0, 1);
      tbl[2]  = mk(0, 8'h00, 0,  1, 8'hA5, 1, 0, 1);
      tbl[3]  = mk(0, 8'h00, 1,  1, 8'hA5, 1, 0, 1);
      tbl[4]  = mk(0, 8'h00, 1,  1, 8'hA5, 1, 0, 1);
      tbl[5]  = mk(0, 8'h00, 1,  0, 8'hA5, 0, 0, 1);
      tbl[6]  = mk(0, 8'h00, 0,  0, 8'hA5, 0, 0, 1);
      tbl[7]  = mk(0, 8'h00, 0,  0, 8'hA5, 0, 0, 1);
      tbl[8]  = mk(0, 8'h00, 0,  0, 8'hA5, 0, 0, 0);
      tbl[9]  = mk(0, 8'h00, 0,  0, 8'hA5, 0, 0, 0);
      tbl[10] = mk(0, 8'h00, 1,  0, 8'hA5, 0, 0, 0);
      tbl[11] = mk(0, 8'h00, 1,  0, 8'hA5, 0, 0, 0);
      tbl[12] = mk(1, 8'h3C, 1,  0, 8'hA5, 1, 0, 1);
      tbl[13] = mk(0, 8'h00, 1,  0, 8'hA5, 1, 0, 1);
      tbl[14] = mk(0, 8'h00, 0,  0, 8'hA5, 1, 0, 1);
      tbl[15] = mk(0, 8'h00, 0,  0, 8'hA5, 1, 0, 1);
      tbl[16] = mk(0, 8'h00, 0,  1, 8'h3C, 1, 0, 1);
      tbl[17] = mk(0, 8'h00, 1,  1, 8'h3C, 1, 0, 1);
      tbl[18] = mk(0, 8'h00, 1,  1, 8'h3C, 1, 0, 1);
      tbl[19] = mk(0, 8'h00, 1,  0, 8'h3C, 0, 0, 1);
      tbl[20] = mk(0, 8'h00, 0,  0, 8'h3C, 0, 0, 1);
      tbl[21] = mk(0, 8'h00, 0,  0, 8'h3C, 0, 0, 1);
      tbl[22] = mk(0, 8'h00, 0,  0, 8'h3C, 0, 0, 0);
      for (int i = 0; i < 23; i++) begin
         pulse = tbl[i].p; din = tbl[i].d; ack = tbl[i].a;
         tick();
         chk($sformatf("tbl%0d_valid", i), int'(output_valid), int'(tbl[i].v));
         chk($sformatf("tbl%0d_byte", i), int'(output_byte), int'(tbl[i].b));
         chk($sformatf("tbl%0d_count", i), int'(fifo_count), tbl[i].c);
         chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].o));
         chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bz));
      end
      pulse = 1'b0; ack = 1'b0;
      repeat (2) tick();

      // Back-to-back pulses fill the FIFO and drain in order.
      pulse = 1'b1; din = 8'h11; tick();
      din = 8'h22; tick();
      pulse = 1'b0;
      chk("b2b_count", int'(fifo_count), 2);
      deliver(8'h11, "b2b_first");
      deliver(8'h22, "b2b_second");
      chk("b2b_ovf", int'(overflow), 0);
      chk("b2b_empty", int'(fifo_count), 0);

      // Push on the pop edge while full is accepted.
      pulse = 1'b1; din = 8'hAA; tick();
      din = 8'hBB; tick();
      pulse = 1'b0;
      chk("pp_full", int'(fifo_count), 2);
      ack = 1'b1; tick(); tick();
      pulse = 1'b1; din = 8'h7E; tick();
      pulse = 1'b0;
      chk("pp_valid", int'(output_valid), 0);
      chk("pp_count", int'(fifo_count), 2);
      chk("pp_ovf", int'(overflow), 0);
      ack = 1'b0;
      repeat (SYNC + 1) tick();
      deliver(8'hBB, "pp_bb");
      deliver(8'h7E, "pp_7e");
      chk("pp_empty", int'(fifo_count), 0);

      // Third pulse into a full FIFO with no pop is dropped.
      pulse = 1'b1; din = 8'h01; tick();
      din = 8'h02; tick();
      chk("ovf_pre", int'(overflow), 0);
      din = 8'h03; tick();
      pulse = 1'b0;
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_count", int'(fifo_count), 2);
      tick();
      chk("ovf_sticky", int'(overflow), 1);
      deliver(8'h01, "ovf_01");
      deliver(8'h02, "ovf_02");
      chk("ovf_still", int'(overflow), 1);
      chk("ovf_empty", int'(fifo_count), 0);

      // Reset in the middle of a request.
      pulse = 1'b1; din = 8'h5A; tick();
      din = 8'h6B; tick();
      pulse = 1'b0;
      chk("mid_req", int'(output_valid), 1);
      nrst = 1'b0; tick();
      nrst = 1'b1;
      chk("mid_valid", int'(output_valid), 0);
      chk("mid_byte", int'(output_byte), 0);
      chk("mid_count", int'(fifo_count), 0);
      chk("mid_ovf", int'(overflow), 0);
      chk("mid_busy", int'(busy), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mid_quiet", int'(output_valid), 0);
      end
      pulse = 1'b1; din = 8'h77; tick();
      pulse = 1'b0;
      deliver(8'h77, "mid_77");

      // Random traffic against a queue model with a reactive ack agent.
      movf = 1'b0; ack_seen_fall = 1'b0; ack_wait = 0; ack_edges = 0; held = '0;
      for (int cyc = 0; cyc < 2200; cyc++) begin
         if (!ack && output_valid) begin
            if (ack_wait == 0) begin
               ack = 1'b1; ack_edges = 0; ack_wait = int'($urandom_range(0, 4));
            end else ack_wait--;
         end else if (ack && ack_seen_fall) begin
            if (ack_wait == 0) begin
               ack = 1'b0; ack_seen_fall = 1'b0; ack_wait = int'($urandom_range(0, 4));
            end else ack_wait--;
         end
         pulse = (cyc < 2000) && ($urandom_range(0, 2) == 0);
         din   = 8'($urandom);
         pv    = output_valid;
         tick();
         if (ack) ack_edges++;
         fell = pv && !output_valid;
         rose = !pv && output_valid;
         if (fell) begin
            chk("rnd_rel_lat", ack_edges, SYNC + 1);
            ack_seen_fall = 1'b1;
            if (q.size() == 0) chk("rnd_pop_empty", 1, 0);
            else void'(q.pop_front());
         end
         acc = pulse && ((q.size() < DEPTH) || fell);
         if (acc) q.push_back(din);
         else if (pulse) movf = 1'b1;
         if (rose) begin
            if (q.size() == 0) chk("rnd_req_empty", 1, 0);
            else chk("rnd_byte", int'(output_byte), int'(q[0]));
            held = output_byte;
         end else if (output_valid) begin
            chk("rnd_stable", int'(output_byte), int'(held));
         end
         chk("rnd_count", int'(fifo_count), q.size());
         chk("rnd_ovf", int'(overflow), int'(movf));
         if (q.size() != 0) chk("rnd_busy", int'(busy), 1);
      end
      chk("end_count", int'(fifo_count), q.size());
      chk("end_busy", int'(busy), 0);
      chk("end_valid", int'(output_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writer.md
# writer

Transmit-side pin interface of the stream cipher. Accepts single-cycle byte pulses from the cipher datapath, buffers them in a small FIFO, and presents each byte on the chip pins with an edge-insensitive 4-phase request/acknowledge handshake driven by the chip. It is the output counterpart of the input pulse converter. It reports `busy` and `overflow` status to the interface FSM.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries. Legal values are powers of two, 2 to 8.
- `SYNC_STAGES`, default 2: flip-flop stages on the asynchronous `output_ack` pin. Minimum 2.

Ports:
- `clk`, input, 1: the single clock.
- `nrst`, input, 1: reset, synchronous, active-low.
- `output_byte_in`, input, 8: byte from the cipher datapath. Valid only when `output_byte_pulse` is high.
- `output_byte_pulse`, input, 1: single-cycle strobe. Pushes `output_byte_in` into the FIFO.
- `output_ack`, input, 1: acknowledge from the chip pin. Asynchronous.
- `output_byte`, output, 8: byte driven to the pins.
- `output_valid`, output, 1: request to the pins, 4-phase.
- `busy`, output, 1: high when the FIFO is not empty or the handshake FSM is not in `W_IDLE`.
- `overflow`, output, 1: sticky flag. Set when a byte is dropped.
- `fifo_count`, output, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO.** Circular buffer with read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
  - `count` ranges from 0 to DEPTH.
  - A push occurs when `output_byte_pulse` is high and `count < DEPTH`.
  - A pop occurs on the FSM transition `W_ASSERT` to `W_RELEASE`.
- **Push and pop in the same cycle.**
  - Both are performed and `count` is unchanged.
  - This holds when full: the pop frees the slot in the same cycle, so the push is accepted.
  - When empty, no pop can occur, so this case does not arise.
- **Overflow.** If `output_byte_pulse` is high while `count == DEPTH` and no pop occurs that cycle, the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- **Ack synchronizer.** `output_ack` passes through `SYNC_STAGES` flops. The last stage, `ack_s`, is the only ack signal the FSM uses.
- **Handshake FSM** (`writer_state_t`):
  - `W_IDLE`, with `output_valid` = 0: if `count > 0` and `ack_s == 0`, load `output_byte` from the FIFO head and go to `W_ASSERT`. If `ack_s` is still high, stay in `W_IDLE`.
  - `W_ASSERT`, with `output_valid` = 1: on `ack_s == 1`, pop the FIFO and go to `W_RELEASE`.
  - `W_RELEASE`, with `output_valid` = 0: on `ack_s == 0`, go to `W_IDLE`.
- **Output registers.**
  - `output_byte` is registered. It is stable from the cycle `output_valid` rises until the next load.
  - It keeps its value through `W_RELEASE` and `W_IDLE`.
  - `output_valid` is registered: high exactly while the state is `W_ASSERT`.
- **Reset values:** state `W_IDLE`; `output_byte` 0; `output_valid` 0; `overflow` 0; `count` 0; read and write pointers 0; all synchronizer flops 0.
- **Reset mid-handshake.**
  - Buffered bytes are discarded and `output_valid` drops on the reset edge.
  - The FSM resumes in `W_IDLE`. It will not start a new request until `ack_s` is observed low.

## Timing
All counts below use `SYNC_STAGES` = 2.
- **Pulse to request.** `output_byte_pulse` sampled at edge N is written to the FIFO at N. The FSM loads it at edge N+1. `output_valid` is high from cycle N+1 onward (latency 1 edge after push).
- **Ack to release.**
  - `output_ack` rising before edge M gives `ack_s` high after edge M+1.
  - At edge M+2 the FSM pops the FIFO and `output_valid` falls.
  - Release latency is `SYNC_STAGES` + 1 edges.
- **Ack low to idle.** `output_ack` falling gives `W_IDLE` after `SYNC_STAGES` + 1 edges. The next `output_valid` rises one edge after that if the FIFO is not empty.
- **Back-to-back pulses.** Pulses on consecutive cycles are all accepted while `count < DEPTH`.
- **`fifo_count` and `busy`.** `fifo_count` updates on the edge of each push or pop. `busy` is combinational from registered state and `count`.

## Structure
- **Shared package.** `writer_state_t` (`W_IDLE`, `W_ASSERT`, `W_RELEASE`) goes in the shared stream-cipher package next to `interface_state_t`, so the interface FSM can reference it.
- **Sub-module `byte_fifo`.** Parameterized by `DEPTH`, 8-bit data.
  - Ports: `clk`, `nrst`, `push`, `push_data`, `pop`, `head_data`, `count`, `full`, `empty`.
  - The overflow flag belongs in `writer`, not in `byte_fifo`.
- **Top level.** The synchronizer and FSM are inline in `writer`.

## Test plan
- **Single byte.** Pulse 0xA5 at cycle 10. Ack model raises ack 3 cycles after `valid`. Required: `valid` high at cycle 11 with `output_byte` = 0xA5; `valid` low 3 edges after ack rises; `busy` low after ack falls plus 3 edges; `count` back to 0.
- **Back-to-back.** Pulses 0x11 and 0x22 on consecutive cycles, `DEPTH` = 2. Required: `fifo_count` reaches 2; pins deliver 0x11 then 0x22 in order; `overflow` stays 0.
- **Overflow.** Pulses 0x01, 0x02, 0x03 on consecutive cycles with ack held low. Required: 0x03 dropped; `overflow` = 1 and stays 1; later 0x01 and 0x02 delivered in order.
- **Push and pop while full.** FIFO full; pulse 0x7E on the same cycle as the pop. Required: 0x7E accepted, `count` stays 2, `overflow` = 0.
- **Stuck-high ack.** `output_ack` still high when a new byte arrives. Required: `valid` stays low until ack falls, then rises `SYNC_STAGES` + 1 edges later.
- **Reset mid-handshake.** Assert `nrst` low for one cycle while in `W_ASSERT`. Required: on the next edge `output_valid` = 0, `output_byte` = 0, `count` = 0, `overflow` = 0; no request until a new pulse arrives.
